layer_scheduler: RTL and testbench
==================================

Name: layer_scheduler

Overview:
- Top-level sequencer for the LeNet-5 layer chain (conv1, pool1, conv2, pool2, conv3, fc1, fc2).
- Runs layers strictly in order: asserts one layer enable at a time and waits for that layer's finish.
- Owns the shared weights/bias BRAM port A and result BRAM port A, muxing them to the active layer.
- Reports busy/done, per-layer and total cycle counts, and a timeout error.

Parameters:
- N_LAYERS, 7, number of sequenced layers; index 0 runs first.
- DATA_SIZE, 16, BRAM data width.
- BW_ADDR_W, 16, weights/bias BRAM address width.
- RES_ADDR_W, 13, result BRAM address width.
- TIMEOUT_CYCLES, 24'hFFFFFF, maximum cycles a layer may stay enabled before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level or pulse; sampled only in S_IDLE/S_ERROR.
- busy  out  1  high from the cycle after start is accepted until done or error.
- done  out  1  one-cycle pulse after the last layer finishes.
- err  out  1  sticky timeout flag; cleared by rst or an accepted start.
- err_layer  out  3  index of the layer that timed out.
- layer_en  out  N_LAYERS  one-hot registered enable.
- layer_finish  in  N_LAYERS  finish flags from the layers.
- layer_bw_ena  in  N_LAYERS  per-layer weights BRAM enable.
- layer_bw_addra  in  N_LAYERS*BW_ADDR_W  packed per-layer weights address; layer i is in slice [i*W +: W].
- layer_res_ena  in  N_LAYERS  per-layer result BRAM enable.
- layer_res_wea  in  N_LAYERS  per-layer result BRAM write enable.
- layer_res_addra  in  N_LAYERS*RES_ADDR_W  packed per-layer result address.
- layer_res_dina  in  N_LAYERS*DATA_SIZE  packed per-layer result write data.
- bias_weights_bram_ena  out  1  to the shared BRAM.
- bias_weights_bram_addra  out  BW_ADDR_W  to the shared BRAM.
- result_bram_ena  out  1  to the shared BRAM.
- result_bram_wea  out  1  to the shared BRAM.
- result_bram_addra  out  RES_ADDR_W  to the shared BRAM.
- result_bram_dina  out  DATA_SIZE  to the shared BRAM.
- layer_cycles  out  24  cycle count of the most recently completed layer.
- total_cycles  out  32  cycles from start acceptance to done; frozen until the next start.

Behaviour:
- Reset values: all outputs 0; state S_IDLE; active index 0; all counters 0.
- States:
  - S_IDLE: on start, clear err, total_cycles and layer index; busy<=1; go to S_ENABLE.
  - S_ENABLE: layer_en<=1<<idx; timeout counter<=0; go to S_WAIT.
  - S_WAIT: timeout counter and total counter increment every cycle.
    - If layer_finish[idx]==1: layer_en<=0 on that same edge and latch layer_cycles; go to S_RELEASE.
    - Else if timeout counter==TIMEOUT_CYCLES-1: layer_en<=0, err<=1, err_layer<=idx, busy<=0; go to S_ERROR.
  - S_RELEASE: one gap cycle with all enables low, so a layer never sees back-to-back enables.
    - If idx==N_LAYERS-1: done<=1 for one cycle, busy<=0; go to S_IDLE.
    - Else idx<=idx+1; go to S_ENABLE.
  - S_ERROR: hold err; on start, behave exactly as start in S_IDLE.
- Finish-to-next-enable latency: exactly 2 cycles (S_RELEASE, then S_ENABLE registers layer_en).
- layer_finish bits of non-active layers are ignored in every state; finish seen in S_IDLE/S_ERROR is ignored.
- Finish and timeout on the same cycle: finish wins, no error.
- start while busy: ignored. Back-to-back runs are allowed: start on the done cycle is accepted from S_IDLE next cycle.
- total_cycles saturates at 32'hFFFFFFFF; layer_cycles is the timeout counter value +1 at finish.
- BRAM mux:
  - Combinational select from the registered active index, qualified by "enable currently high".
  - When no layer is enabled (S_IDLE, S_ENABLE, S_RELEASE, S_ERROR): ena=0, wea=0, and addr/dina driven 0.
  - An inactive layer's requests never reach the BRAMs.
- rst mid-run: all enables drop on the reset edge; BRAM ena/wea are 0 the next cycle; state returns to S_IDLE.

Decomposition:
- Shared package: DATA_SIZE, address widths, layer index constants (L_CONV1=0 … L_FC2=6), state encodings (one-hot, 5 bits).
- One sub-module, bram_port_mux: parameterised N-to-1 mux for one BRAM port (ena/wea/addr/din) with a select-valid input.
- Instantiate bram_port_mux twice: the weights port with wea/din unused, and the result port.

Test Plan:
- Stub layers that raise finish k cycles after enable (k=10,20,…,70); pulse start.
  - layer_en walks 0000001→1000000.
  - Each enable rises 2 cycles after the previous finish.
  - done pulses once; layer_cycles after fc2 = 70.
  - total_cycles equals the sum of the active windows plus the gap cycles.
- During the fc1 window, every stub drives a distinct addra (i*100).
  - Shared BRAM addra equals 500 only while layer_en[5]=1.
  - result_bram_ena=0 in all gap cycles.
- Stub 3 never finishes, TIMEOUT_CYCLES=50.
  - err=1, err_layer=3, busy=0 and layer_en=0 after exactly 50 wait cycles.
  - A new start clears err and restarts at layer 0.
- Stub 4 asserts finish on the same cycle its timeout counter hits TIMEOUT_CYCLES-1 → no err; sequencing continues to layer 5.
- Stubs 0 and 6 assert spurious finish while layer 2 is active; start is re-pulsed mid-run → no effect on idx, busy or done.
- Assert rst while layer 4 is enabled.
  - Next cycle: layer_en=0, BRAM ena/wea=0, busy=0.
  - A subsequent start runs the full chain cleanly.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// Shared constants, layer indices and FSM encoding for the LeNet-5 layer sequencer.
package layer_scheduler_pkg;

    localparam int unsigned N_LAYERS   = 7;
    localparam int unsigned DATA_SIZE  = 16;
    localparam int unsigned BW_ADDR_W  = 16;
    localparam int unsigned RES_ADDR_W = 13;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned LCYC_W     = 24;
    localparam int unsigned TCYC_W     = 32;

    localparam logic [IDX_W-1:0] L_CONV1 = 3'd0;
    localparam logic [IDX_W-1:0] L_POOL1 = 3'd1;
    localparam logic [IDX_W-1:0] L_CONV2 = 3'd2;
    localparam logic [IDX_W-1:0] L_POOL2 = 3'd3;
    localparam logic [IDX_W-1:0] L_CONV3 = 3'd4;
    localparam logic [IDX_W-1:0] L_FC1   = 3'd5;
    localparam logic [IDX_W-1:0] L_FC2   = 3'd6;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_ENABLE  = 5'b00010,
        S_WAIT    = 5'b00100,
        S_RELEASE = 5'b01000,
        S_ERROR   = 5'b10000
    } state_e;

    // One-hot enable vector for a layer index.
    function automatic logic [N_LAYERS-1:0] layer_onehot(input logic [IDX_W-1:0] idx);
        layer_onehot = N_LAYERS'(1) << idx;
    endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Layer-side handshake/BRAM request bus plus the shared BRAM port-A outputs.
interface layer_scheduler_if;
    import layer_scheduler_pkg::*;

    logic [N_LAYERS-1:0]            layer_en;
    logic [N_LAYERS-1:0]            layer_finish;
    logic [N_LAYERS-1:0]            layer_bw_ena;
    logic [N_LAYERS*BW_ADDR_W-1:0]  layer_bw_addra;
    logic [N_LAYERS-1:0]            layer_res_ena;
    logic [N_LAYERS-1:0]            layer_res_wea;
    logic [N_LAYERS*RES_ADDR_W-1:0] layer_res_addra;
    logic [N_LAYERS*DATA_SIZE-1:0]  layer_res_dina;

    logic                  bias_weights_bram_ena;
    logic [BW_ADDR_W-1:0]  bias_weights_bram_addra;
    logic                  result_bram_ena;
    logic                  result_bram_wea;
    logic [RES_ADDR_W-1:0] result_bram_addra;
    logic [DATA_SIZE-1:0]  result_bram_dina;

    modport master (
        output layer_en,
        input  layer_finish, layer_bw_ena, layer_bw_addra,
        input  layer_res_ena, layer_res_wea, layer_res_addra, layer_res_dina,
        output bias_weights_bram_ena, bias_weights_bram_addra,
        output result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );

    modport slave (
        input  layer_en,
        output layer_finish, layer_bw_ena, layer_bw_addra,
        output layer_res_ena, layer_res_wea, layer_res_addra, layer_res_dina,
        input  bias_weights_bram_ena, bias_weights_bram_addra,
        input  result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );

endinterface

// File: rtl/layer_scheduler_bram_port_mux.sv
// N-to-1 combinational mux for one BRAM port; outputs are all-zero unless the select is valid.
module bram_port_mux #(
    parameter int unsigned N      = 7,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    input  logic [N-1:0]        ena_in,
    input  logic [N-1:0]        wea_in,
    input  logic [N*ADDR_W-1:0] addr_in,
    input  logic [N*DATA_W-1:0] din_in,
    output logic                ena_c,
    output logic                wea_c,
    output logic [ADDR_W-1:0]   addr_c,
    output logic [DATA_W-1:0]   din_c
);

    always_comb begin
        ena_c  = 1'b0;
        wea_c  = 1'b0;
        addr_c = '0;
        din_c  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel_valid && sel == SEL_W'(i)) begin
                ena_c  = ena_in[i];
                wea_c  = wea_in[i];
                addr_c = addr_in[i*ADDR_W +: ADDR_W];
                din_c  = din_in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences the LeNet-5 layers one at a time, muxes the shared BRAM ports to the
// active layer, and reports busy/done, cycle counts and a per-layer timeout.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IDX_W-1:0]     err_layer,
    output logic [LCYC_W-1:0]    layer_cycles,
    output logic [TCYC_W-1:0]    total_cycles,
    layer_scheduler_if.master    bus
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LCYC_W-1:0]   tcnt_q, tcnt_d;
    logic [N_LAYERS-1:0] en_d;
    logic                busy_d, done_d, err_d;
    logic [IDX_W-1:0]    err_layer_d;
    logic [LCYC_W-1:0]   layer_cycles_d;
    logic [TCYC_W-1:0]   total_d, total_inc;

    assign total_inc = (total_cycles == '1) ? total_cycles : total_cycles + TCYC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tcnt_q       <= '0;
            bus.layer_en <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_layer    <= '0;
            layer_cycles <= '0;
            total_cycles <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            bus.layer_en <= en_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            err_layer    <= err_layer_d;
            layer_cycles <= layer_cycles_d;
            total_cycles <= total_d;
        end
    end

    // Next-state and next-output logic; finish is checked ahead of timeout so it wins a tie.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tcnt_d         = tcnt_q;
        en_d           = bus.layer_en;
        busy_d         = busy;
        done_d         = 1'b0;
        err_d          = err;
        err_layer_d    = err_layer;
        layer_cycles_d = layer_cycles;
        total_d        = total_cycles;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    err_d   = 1'b0;
                    total_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ENABLE;
                end
            end
            S_ENABLE: begin
                en_d    = layer_onehot(idx_q);
                tcnt_d  = '0;
                total_d = total_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d  = tcnt_q + LCYC_W'(1);
                total_d = total_inc;
                if (bus.layer_finish[idx_q]) begin
                    en_d           = '0;
                    layer_cycles_d = tcnt_q + LCYC_W'(1);
                    state_d        = S_RELEASE;
                end else if (tcnt_q == LCYC_W'(TIMEOUT_CYCLES - 1)) begin
                    en_d        = '0;
                    err_d       = 1'b1;
                    err_layer_d = idx_q;
                    busy_d      = 1'b0;
                    state_d     = S_ERROR;
                end
            end
            S_RELEASE: begin
                total_d = total_inc;
                if (idx_q == IDX_W'(N_LAYERS - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ENABLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic                 sel_valid;
    logic                 bw_wea_unused;
    logic [DATA_SIZE-1:0] bw_din_unused;

    assign sel_valid = |bus.layer_en;

    bram_port_mux #(
        .N(N_LAYERS), .ADDR_W(BW_ADDR_W), .DATA_W(DATA_SIZE), .SEL_W(IDX_W)
    ) u_bw_mux (
        .sel       (idx_q),
        .sel_valid (sel_valid),
        .ena_in    (bus.layer_bw_ena),
        .wea_in    ('0),
        .addr_in   (bus.layer_bw_addra),
        .din_in    ('0),
        .ena_c     (bus.bias_weights_bram_ena),
        .wea_c     (bw_wea_unused),
        .addr_c    (bus.bias_weights_bram_addra),
        .din_c     (bw_din_unused)
    );

    bram_port_mux #(
        .N(N_LAYERS), .ADDR_W(RES_ADDR_W), .DATA_W(DATA_SIZE), .SEL_W(IDX_W)
    ) u_res_mux (
        .sel       (idx_q),
        .sel_valid (sel_valid),
        .ena_in    (bus.layer_res_ena),
        .wea_in    (bus.layer_res_wea),
        .addr_in   (bus.layer_res_addra),
        .din_in    (bus.layer_res_dina),
        .ena_c     (bus.result_bram_ena),
        .wea_c     (bus.result_bram_wea),
        .addr_c    (bus.result_bram_addra),
        .din_c     (bus.result_bram_dina)
    );

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: stub layers with programmable finish delay, table and random runs.
module tb_layer_scheduler;
    import layer_scheduler_pkg::*;

    localparam int unsigned TB_TIMEOUT = 80;
    localparam int unsigned RUN_BUDGET = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [2:0]  err_layer;
    logic [23:0] layer_cycles;
    logic [31:0] total_cycles;

    layer_scheduler_if bus();

    layer_scheduler #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_layer    (err_layer),
        .layer_cycles (layer_cycles),
        .total_cycles (total_cycles),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Stub layers: finish k cycles after enable (k==0 never finishes); spur forces finish bits.
    int unsigned         kk  [N_LAYERS];
    int unsigned         cnt [N_LAYERS];
    logic [N_LAYERS-1:0] spur;

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N_LAYERS); i++)
            cnt[i] <= bus.layer_en[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        bus.layer_finish = spur;
        for (int i = 0; i < int'(N_LAYERS); i++)
            if (bus.layer_en[i] && kk[i] != 0 && cnt[i] == kk[i] - 1)
                bus.layer_finish[i] = 1'b1;
    end

    always_comb begin
        bus.layer_bw_ena    = '1;
        bus.layer_res_ena   = '1;
        bus.layer_res_wea   = '1;
        bus.layer_bw_addra  = '0;
        bus.layer_res_addra = '0;
        bus.layer_res_dina  = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            bus.layer_bw_addra[i*BW_ADDR_W +: BW_ADDR_W]    = BW_ADDR_W'(i * 100);
            bus.layer_res_addra[i*RES_ADDR_W +: RES_ADDR_W] = RES_ADDR_W'(i * 100 + 3);
            bus.layer_res_dina[i*DATA_SIZE +: DATA_SIZE]    = DATA_SIZE'(i * 1000 + 7);
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Run-level reference: each finished layer costs k+2 busy cycles, a hung layer 1+timeout.
    task automatic model_run(input int unsigned k[N_LAYERS], input logic [23:0] prev_lc,
                             output logic e, output logic [2:0] el,
                             output logic [31:0] tot, output logic [23:0] lc);
        e = 1'b0; el = '0; tot = '0; lc = prev_lc;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            if (k[i] == 0) begin
                e   = 1'b1;
                el  = 3'(i);
                tot = tot + 32'(1 + TB_TIMEOUT);
                break;
            end
            tot = tot + 32'(k[i] + 2);
            lc  = 24'(k[i]);
        end
    endtask

    // Pulses start from the current negedge, then watches the whole chain cycle by cycle.
    task automatic run_chain(input string name, input logic e, input logic [2:0] el,
                             input logic [31:0] tot, input logic [23:0] lc);
        logic [N_LAYERS-1:0] prev_en = '0;
        int  exp_idx  = 0;
        int  low      = 0;
        int  win      = 0;
        int  last_win = 0;
        int  a;
        bit  first    = 1'b1;
        bit  ended    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "/accept_busy"}, 64'(busy), 64'(1));
        chk({name, "/accept_err_clr"}, 64'(err), 64'(0));
        chk({name, "/done_one_cycle"}, 64'(done), 64'(0));
        for (int c = 0; c < int'(RUN_BUDGET); c++) begin
            @(negedge clk);
            if (bus.layer_en != '0) begin
                chk({name, "/onehot"}, 64'($countones(bus.layer_en)), 64'(1));
                if (prev_en == '0) begin
                    chk({name, "/walk"}, 64'(bus.layer_en), 64'(1) << exp_idx);
                    if (!first) chk({name, "/gap"}, 64'(low), 64'(2));
                    first = 1'b0;
                    exp_idx++;
                end
                win++;
                a = exp_idx - 1;
                chk({name, "/bw_mux"},
                    {47'(0), bus.bias_weights_bram_ena, bus.bias_weights_bram_addra},
                    {47'(0), 1'b1, 16'(a * 100)});
                chk({name, "/res_mux"},
                    {32'(0), bus.result_bram_ena, bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina},
                    {32'(0), 1'b1, 1'b1, 13'(a * 100 + 3), 16'(a * 1000 + 7)});
            end else begin
                chk({name, "/gap_mux"},
                    {17'(0), bus.bias_weights_bram_ena, bus.bias_weights_bram_addra, bus.result_bram_ena,
                     bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina}, 64'(0));
                if (prev_en != '0) begin
                    last_win = win;
                    win      = 0;
                    low      = 0;
                end
                low++;
            end
            prev_en = bus.layer_en;
            if (done || err) begin
                ended = 1'b1;
                break;
            end
        end
        chk({name, "/ended"}, 64'(ended), 64'(1));
        chk({name, "/err"}, 64'(err), 64'(e));
        chk({name, "/done"}, 64'(done), 64'(!e));
        if (e) chk({name, "/err_layer"}, 64'(err_layer), 64'(el));
        chk({name, "/busy_low"}, 64'(busy), 64'(0));
        chk({name, "/en_low"}, 64'(bus.layer_en), 64'(0));
        chk({name, "/total"}, 64'(total_cycles), 64'(tot));
        chk({name, "/layer_cycles"}, 64'(layer_cycles), 64'(lc));
        chk({name, "/last_window"}, 64'(last_win), e ? 64'(TB_TIMEOUT) : 64'(lc));
        chk({name, "/layers_run"}, 64'(exp_idx), e ? 64'(el) + 64'(1) : 64'(N_LAYERS));
    endtask

    typedef struct {
        int unsigned k[N_LAYERS];
        logic        e;
        logic [2:0]  el;
        logic [31:0] tot;
        logic [23:0] lc;
    } vec_t;

    vec_t        tbl[6];
    logic [23:0] cur_lc;
    logic        m_e;
    logic [2:0]  m_el;
    logic [31:0] m_tot;
    logic [23:0] m_lc;
    bit          hit;

    initial begin
        tbl[0] = '{k: '{1, 1, 1, 1, 1, 1, 1},         e: 1'b0, el: 3'd0, tot: 32'd21,  lc: 24'd1};
        tbl[1] = '{k: '{10, 20, 30, 40, 50, 60, 70},  e: 1'b0, el: 3'd0, tot: 32'd294, lc: 24'd70};
        tbl[2] = '{k: '{5, 5, 5, 0, 5, 5, 5},         e: 1'b1, el: 3'd3, tot: 32'd102, lc: 24'd5};
        tbl[3] = '{k: '{2, 2, 2, 2, 80, 2, 2},        e: 1'b0, el: 3'd0, tot: 32'd106, lc: 24'd2};
        tbl[4] = '{k: '{0, 3, 3, 3, 3, 3, 3},         e: 1'b1, el: 3'd0, tot: 32'd81,  lc: 24'd2};
        tbl[5] = '{k: '{3, 1, 4, 1, 5, 9, 2},         e: 1'b0, el: 3'd0, tot: 32'd39,  lc: 24'd2};

        rst = 1'b1; start = 1'b0; spur = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) kk[i] = 1;
        repeat (3) @(negedge clk);
        chk("reset/busy", 64'(busy), 64'(0));
        chk("reset/done", 64'(done), 64'(0));
        chk("reset/err", 64'(err), 64'(0));
        chk("reset/err_layer", 64'(err_layer), 64'(0));
        chk("reset/layer_en", 64'(bus.layer_en), 64'(0));
        chk("reset/counters", {8'(0), layer_cycles, total_cycles}, 64'(0));
        chk("reset/bram", {62'(0), bus.bias_weights_bram_ena, bus.result_bram_ena}, 64'(0));
        rst = 1'b0;
        cur_lc = '0;
        @(negedge clk);

        // Table runs, chained back to back (start raised in the done/err cycle).
        for (int t = 0; t < 6; t++) begin
            kk = tbl[t].k;
            run_chain($sformatf("tbl%0d", t), tbl[t].e, tbl[t].el, tbl[t].tot, tbl[t].lc);
            cur_lc = tbl[t].lc;
        end

        // Random runs against the run-level model.
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < int'(N_LAYERS); i++) begin
                case ($urandom_range(0, 9))
                    0:       kk[i] = 0;
                    1:       kk[i] = TB_TIMEOUT;
                    default: kk[i] = $urandom_range(1, 25);
                endcase
            end
            model_run(kk, cur_lc, m_e, m_el, m_tot, m_lc);
            run_chain($sformatf("rnd%0d", r), m_e, m_el, m_tot, m_lc);
            cur_lc = m_lc;
        end

        // Finish flags while idle are ignored.
        for (int i = 0; i < int'(N_LAYERS); i++) kk[i] = 12;
        repeat (2) @(negedge clk);
        spur = '1;
        repeat (3) @(negedge clk);
        chk("idle_finish/busy", 64'(busy), 64'(0));
        chk("idle_finish/en", 64'(bus.layer_en), 64'(0));
        chk("idle_finish/done", 64'(done), 64'(0));
        spur = '0;

        // Spurious finishes from inactive layers and a re-pulsed start during layer 2.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.layer_en[2]) begin hit = 1'b1; break; end
        end
        chk("spur/reach_l2", 64'(hit), 64'(1));
        spur  = 7'b1000001;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("spur/en_held", 64'(bus.layer_en), 64'(7'b0000100));
            chk("spur/busy", 64'(busy), 64'(1));
            chk("spur/done", 64'(done), 64'(0));
        end
        spur  = '0;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < int'(RUN_BUDGET); c++) begin
            @(negedge clk);
            if (done || err) begin hit = 1'b1; break; end
        end
        chk("spur/done_seen", 64'(hit), 64'(1));
        chk("spur/err", 64'(err), 64'(0));
        chk("spur/total", 64'(total_cycles), 64'(98));
        chk("spur/layer_cycles", 64'(layer_cycles), 64'(12));
        @(negedge clk);
        chk("spur/done_pulse", 64'(done), 64'(0));

        // Reset while layer 4 is enabled, then a clean full run.
        for (int i = 0; i < int'(N_LAYERS); i++) kk[i] = 15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.layer_en[4]) begin hit = 1'b1; break; end
        end
        chk("rst_mid/reach_l4", 64'(hit), 64'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid/en", 64'(bus.layer_en), 64'(0));
        chk("rst_mid/bram", {61'(0), bus.bias_weights_bram_ena, bus.result_bram_ena, bus.result_bram_wea}, 64'(0));
        chk("rst_mid/busy", 64'(busy), 64'(0));
        chk("rst_mid/counters", {8'(0), layer_cycles, total_cycles}, 64'(0));
        rst = 1'b0;
        cur_lc = '0;
        @(negedge clk);
        run_chain("after_rst", 1'b0, 3'd0, 32'd119, 24'd15);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
